// File: rtl/arm_sram_ctrl_if.sv
// arm_sram_ctrl_if: CPU request/response and SRAM pin bundle; master = pipeline + SRAM device side, slave = controller
interface arm_sram_ctrl_if #(
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 18
);
  logic                   rd_en;
  logic                   wr_en;
  logic [31:0]            address;
  logic [DATA_W-1:0]      write_data;
  logic [DATA_W-1:0]      read_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0]      sram_dq_out;
  logic [DATA_W-1:0]      sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;
  logic [31:0]            stall_cnt;
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, stall_cnt
  );
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, stall_cnt
  );
endinterface

// File: rtl/arm_sram_ctrl.sv
// arm_sram_ctrl: MEM-stage controller turning one-cycle load/store requests into WAIT_CYCLES-long async SRAM accesses (clk, rst, bus.slave)
module arm_sram_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5
) (
  input logic            clk,
  input logic            rst,
  arm_sram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t                 state;
  logic [3:0]             cnt;
  logic                   wr_op;
  logic [DATA_W-1:0]      rdata;
  logic [DATA_W-1:0]      dq_out;
  logic [SRAM_ADDR_W-1:0] addr;
  logic [31:0]            stall_q;
  logic                   req;
  logic [31:0]            offset;
  assign req             = bus.rd_en | bus.wr_en;
  assign offset          = bus.address - BASE_ADDR;
  assign bus.ready       = (state == IDLE && !req) || state == DONE;
  assign bus.read_data   = rdata;
  assign bus.sram_addr   = addr;
  assign bus.sram_dq_out = dq_out;
  assign bus.sram_dq_oe  = wr_op;
  assign bus.sram_we_n   = ~wr_op;
  assign bus.stall_cnt   = stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_op   <= 1'b0;
      rdata   <= '0;
      dq_out  <= '0;
      addr    <= '0;
      stall_q <= '0;
    end else begin
      if (!bus.ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      case (state)
        IDLE: if (req) begin
          state  <= ACCESS;
          addr   <= SRAM_ADDR_W'(offset >> 2);
          dq_out <= bus.write_data;
          wr_op  <= bus.wr_en;
          cnt    <= 4'(WAIT_CYCLES - 1);
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == '0) begin
            state <= DONE;
            wr_op <= 1'b0;
            if (!wr_op) rdata <= bus.sram_dq_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
